// File: rtl/tetris_board_clear_master.sv
// Avalon-MM master that removes full rows from the playfield, compacts the rest downward and zero-fills the top.
// Optional scoring is enabled by defining TETRIS_BOARD_CLEAR_SCORE_EN.
module tetris_board_clear_master #(
   parameter int          ROWS      = 20,
   parameter int          COLS      = 10,
   parameter logic [14:0] BASE_ADDR = 15'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  lines_cleared,
   output logic [31:0] score,
   output logic [14:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   input  logic        avm_waitrequest
);

   localparam logic [31:0] COL_MASK = 32'hFFFF_FFFF >> (32 - COLS);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_FILL    = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t      r_state, w_nxt_state;
   logic [4:0]  r_rd_idx, w_nxt_rd_idx;
   logic [4:0]  r_wr_idx, w_nxt_wr_idx;
   logic [4:0]  r_cnt, w_nxt_cnt;
   logic        r_busy, w_nxt_busy;
   logic        r_done, w_nxt_done;
   logic [4:0]  r_lines, w_nxt_lines;
   logic [14:0] r_addr, w_nxt_addr;
   logic        r_read, w_nxt_read;
   logic        r_write, w_nxt_write;
   logic [31:0] r_wdata, w_nxt_wdata;
   logic        w_row_full;
   logic        w_advance;
   logic        w_finish;

   assign busy           = r_busy;
   assign done           = r_done;
   assign lines_cleared  = r_lines;
   assign avm_address    = r_addr;
   assign avm_read       = r_read;
   assign avm_write      = r_write;
   assign avm_byteenable = 4'hF;
   assign avm_writedata  = r_wdata;

   // Next-state and next-output logic; outputs are computed one cycle ahead so they leave the block registered
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_rd_idx = r_rd_idx;
      w_nxt_wr_idx = r_wr_idx;
      w_nxt_cnt    = r_cnt;
      w_nxt_busy   = r_busy;
      w_nxt_done   = 1'b0;
      w_nxt_lines  = r_lines;
      w_nxt_addr   = r_addr;
      w_nxt_read   = r_read;
      w_nxt_write  = r_write;
      w_nxt_wdata  = r_wdata;
      w_advance    = 1'b0;
      w_finish     = 1'b0;
      w_row_full   = ((avm_readdata & COL_MASK) == COL_MASK);

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt_state  = S_RD_REQ;
               w_nxt_rd_idx = LAST_ROW;
               w_nxt_wr_idx = LAST_ROW;
               w_nxt_cnt    = 5'd0;
               w_nxt_busy   = 1'b1;
               w_nxt_read   = 1'b1;
               w_nxt_addr   = BASE_ADDR + 15'(LAST_ROW);
            end else begin
               w_nxt_state = S_IDLE;
            end
         end
         S_RD_REQ: begin
            if (!avm_waitrequest) begin
               w_nxt_read  = 1'b0;
               w_nxt_state = S_RD_WAIT;
            end else begin
               w_nxt_state = S_RD_REQ;
            end
         end
         S_RD_WAIT: begin
            if (!avm_readdatavalid) begin
               w_nxt_state = S_RD_WAIT;
            end else if (w_row_full) begin
               w_nxt_cnt = r_cnt + 5'd1;
               w_advance = 1'b1;
            end else if (r_wr_idx == r_rd_idx) begin
               w_nxt_wr_idx = r_wr_idx - 5'd1;
               w_advance    = 1'b1;
            end else begin
               w_nxt_state = S_WR_REQ;
               w_nxt_write = 1'b1;
               w_nxt_addr  = BASE_ADDR + 15'(r_wr_idx);
               w_nxt_wdata = avm_readdata & COL_MASK;
            end
         end
         S_WR_REQ: begin
            if (!avm_waitrequest) begin
               w_nxt_write  = 1'b0;
               w_nxt_wr_idx = r_wr_idx - 5'd1;
               w_advance    = 1'b1;
            end else begin
               w_nxt_state = S_WR_REQ;
            end
         end
         S_FILL: begin
            // An idle FILL (no write raised on entry) means nothing was cleared
            if (!r_write) begin
               w_finish = 1'b1;
            end else if (avm_waitrequest) begin
               w_nxt_state = S_FILL;
            end else if (r_wr_idx == 5'd0) begin
               w_nxt_write = 1'b0;
               w_finish    = 1'b1;
            end else begin
               w_nxt_wr_idx = r_wr_idx - 5'd1;
               w_nxt_addr   = BASE_ADDR + 15'(r_wr_idx - 5'd1);
            end
         end
         S_DONE: begin
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_busy  = 1'b0;
            w_nxt_read  = 1'b0;
            w_nxt_write = 1'b0;
         end
      endcase

      if (w_advance) begin
         if (r_rd_idx == 5'd0) begin
            w_nxt_state = S_FILL;
            w_nxt_write = (w_nxt_cnt != 5'd0);
            w_nxt_addr  = BASE_ADDR + 15'(w_nxt_wr_idx);
            w_nxt_wdata = 32'h0000_0000;
         end else begin
            w_nxt_state  = S_RD_REQ;
            w_nxt_rd_idx = r_rd_idx - 5'd1;
            w_nxt_read   = 1'b1;
            w_nxt_addr   = BASE_ADDR + 15'(r_rd_idx - 5'd1);
         end
      end else begin
         w_nxt_rd_idx = w_nxt_rd_idx;
      end

      if (w_finish) begin
         w_nxt_state = S_DONE;
         w_nxt_busy  = 1'b0;
         w_nxt_done  = 1'b1;
         w_nxt_lines = r_cnt;
      end else begin
         w_nxt_done = w_nxt_done;
      end
   end

   // State, index and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_rd_idx <= 5'd0;
         r_wr_idx <= 5'd0;
         r_cnt    <= 5'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_lines  <= 5'd0;
         r_addr   <= BASE_ADDR;
         r_read   <= 1'b0;
         r_write  <= 1'b0;
         r_wdata  <= 32'h0000_0000;
      end else begin
         r_state  <= w_nxt_state;
         r_rd_idx <= w_nxt_rd_idx;
         r_wr_idx <= w_nxt_wr_idx;
         r_cnt    <= w_nxt_cnt;
         r_busy   <= w_nxt_busy;
         r_done   <= w_nxt_done;
         r_lines  <= w_nxt_lines;
         r_addr   <= w_nxt_addr;
         r_read   <= w_nxt_read;
         r_write  <= w_nxt_write;
         r_wdata  <= w_nxt_wdata;
      end
   end

`ifdef TETRIS_BOARD_CLEAR_SCORE_EN
   logic [31:0] r_score;
   logic [32:0] w_score_sum;

   // Points: 1200 per group of four lines plus the classic table for the remainder
   function automatic logic [31:0] f_line_points(input logic [4:0] n);
      logic [31:0] v_rem;
      case (n[1:0])
         2'd0:    v_rem = 32'd0;
         2'd1:    v_rem = 32'd40;
         2'd2:    v_rem = 32'd100;
         2'd3:    v_rem = 32'd300;
         default: v_rem = 32'd0;
      endcase
      return (32'd1200 * {29'd0, n[4:2]}) + v_rem;
   endfunction

   // Widened sum so saturation can be detected from the carry
   always_comb begin
      w_score_sum = {1'b0, r_score} + {1'b0, f_line_points(r_cnt)};
   end

   // Score accumulates once per completed pass and clears only on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_score <= 32'h0000_0000;
      end else if (w_finish) begin
         r_score <= w_score_sum[32] ? 32'hFFFF_FFFF : w_score_sum[31:0];
      end else begin
         r_score <= r_score;
      end
   end

   assign score = r_score;
`else
   assign score = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_tetris_board_clear_master.sv
// Self-checking bench for tetris_board_clear_master: Avalon slave with optional random stalls/latency
// and a row-list reference model of the clear pass.
module tb_tetris_board_clear_master;
   localparam int          ROWS = 20;
   localparam int          COLS = 10;
   localparam logic [31:0] FULL = 32'h0000_03FF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic [4:0]  lines_cleared;
   logic [31:0] score;
   logic [14:0] avm_address;
   logic        avm_read, avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = 32'h0;
   logic        avm_readdatavalid = 1'b0;
   logic        avm_waitrequest = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem      [0:31];
   logic [31:0] init_mem [0:31];
   logic [31:0] exp_mem  [0:31];
   int          exp_waddr[$];
   int          waddr_q[$];
   int          n_reads = 0;
   int          proto_bad = 0;
   bit          rand_mode = 1'b0;
   longint      exp_score = 0;

   bit          pend = 1'b0;
   int          cnt_down = 0;
   logic [31:0] pend_data;
   bit          prev_stall = 1'b0;
   logic        prev_rd, prev_wr;
   logic [14:0] prev_addr;
   logic [31:0] prev_wd;

   always #5 clk = ~clk;

   tetris_board_clear_master #(.ROWS(ROWS), .COLS(COLS), .BASE_ADDR(15'h0000)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .lines_cleared(lines_cleared), .score(score),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest)
   );

   // Avalon slave: decides waitrequest for the coming edge, records accepted commands, returns read data
   always begin
      @(negedge clk);
      #1;
      if (pend) begin
         cnt_down = cnt_down - 1;
         if (cnt_down == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
            pend              = 1'b0;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
         end
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
      end
      if (avm_read && avm_write) proto_bad++;
      if (avm_byteenable !== 4'hF) proto_bad++;
      if ((avm_writedata & ~FULL) != 32'h0) proto_bad++;
      if (prev_stall && !reset && (avm_read !== prev_rd || avm_write !== prev_wr ||
          avm_address !== prev_addr || (prev_wr && avm_writedata !== prev_wd))) proto_bad++;
      if (reset) begin
         avm_waitrequest   = 1'b1;
         avm_readdatavalid = 1'b0;
         pend              = 1'b0;
         prev_stall        = 1'b0;
      end else begin
         avm_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
         if (avm_read && !avm_waitrequest) begin
            n_reads++;
            pend      = 1'b1;
            cnt_down  = rand_mode ? int'($urandom_range(1, 4)) : 1;
            pend_data = mem[avm_address[4:0]];
         end
         if (avm_write && !avm_waitrequest) begin
            mem[avm_address[4:0]] = avm_writedata;
            waddr_q.push_back(int'(avm_address));
         end
         prev_stall = (avm_read || avm_write) && avm_waitrequest;
         prev_rd    = avm_read;
         prev_wr    = avm_write;
         prev_addr  = avm_address;
         prev_wd    = avm_writedata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint line_points(input int n);
      int tbl[4] = '{0, 40, 100, 300};
      return longint'(1200 * (n / 4) + tbl[n % 4]);
   endfunction

   // Reference: bottom-up list of surviving rows, placed from the bottom; rows already in place are not rewritten
   task automatic model_pass(output int cnt);
      int w;
      cnt = 0;
      w   = ROWS - 1;
      exp_waddr.delete();
      for (int i = 0; i < 32; i++) exp_mem[i] = init_mem[i];
      for (int r = ROWS - 1; r >= 0; r--) begin
         if ((init_mem[r] & FULL) == FULL) begin
            cnt++;
         end else begin
            if (w != r) begin
               exp_mem[w] = init_mem[r] & FULL;
               exp_waddr.push_back(w);
            end
            w--;
         end
      end
      for (int i = w; i >= 0; i--) begin
         exp_mem[i] = 32'h0;
         exp_waddr.push_back(i);
      end
   endtask

   task automatic run_pass(input string tag, input bit hold_start);
      int cnt, cyc, extra;
      bit got;
      for (int i = 0; i < 32; i++) mem[i] = init_mem[i];
      model_pass(cnt);
`ifdef TETRIS_BOARD_CLEAR_SCORE_EN
      exp_score = exp_score + line_points(cnt);
      if (exp_score > 64'hFFFF_FFFF) exp_score = 64'hFFFF_FFFF;
`endif
      n_reads = 0;
      proto_bad = 0;
      waddr_q.delete();
      @(negedge clk);
      start = 1'b1;
      if (!hold_start) begin
         @(negedge clk);
         start = 1'b0;
      end
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) got = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_lines"}, {27'd0, lines_cleared}, 32'(cnt));
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_score"}, score, exp_score[31:0]);
      extra = 0;
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) extra++;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      chk({tag, "_single_pass"}, 32'(extra), 32'd0);
      chk({tag, "_reads"}, 32'(n_reads), 32'(ROWS));
      chk({tag, "_proto"}, 32'(proto_bad), 32'd0);
      chk({tag, "_nwrites"}, 32'(waddr_q.size()), 32'(exp_waddr.size()));
      if (waddr_q.size() == exp_waddr.size())
         for (int i = 0; i < exp_waddr.size(); i++)
            chk({tag, "_waddr"}, 32'(waddr_q[i]), 32'(exp_waddr[i]));
      for (int r = 0; r < ROWS; r++) chk({tag, "_row"}, mem[r], exp_mem[r]);
   endtask

   task automatic board_clear();
      for (int i = 0; i < 32; i++) init_mem[i] = 32'h0;
   endtask

   task automatic board_two_lines();
      board_clear();
      init_mem[19] = 32'h0000_03FF;
      init_mem[18] = 32'h0000_03FF;
      init_mem[17] = 32'h0000_0001;
   endtask

   initial begin
      board_clear();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_lines", {27'd0, lines_cleared}, 32'd0);
      chk("rst_score", score, 32'd0);
      chk("rst_read", {31'd0, avm_read}, 32'd0);
      chk("rst_write", {31'd0, avm_write}, 32'd0);
      chk("rst_addr", {17'd0, avm_address}, 32'd0);
      chk("rst_wdata", avm_writedata, 32'd0);
      reset = 1'b0;

      rand_mode = 1'b0;
      board_clear();
      run_pass("empty", 1'b0);

      board_two_lines();
      run_pass("two_lines", 1'b0);

      board_clear();
      init_mem[10] = 32'h0000_03FF;
      init_mem[9]  = 32'hFFFF_FC05;
      run_pass("upper_bits", 1'b0);
      chk("upper_bits_row10", mem[10], 32'h0000_0005);

      rand_mode = 1'b1;
      board_two_lines();
      run_pass("two_lines_stall", 1'b0);

      board_clear();
      for (int r = 0; r < ROWS; r++) init_mem[r] = FULL | ($urandom & 32'hFFFF_FC00);
      run_pass("all_full", 1'b0);

      for (int p = 0; p < 4; p++) begin
         rand_mode = p[0];
         for (int r = 0; r < ROWS; r++)
            init_mem[r] = ($urandom_range(0, 99) < 40) ? (FULL | ($urandom & 32'hFFFF_FC00)) : $urandom;
         run_pass("random", 1'b0);
      end

      rand_mode = 1'b0;
      board_two_lines();
      for (int i = 0; i < 32; i++) mem[i] = init_mem[i];
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_read", {31'd0, avm_read}, 32'd0);
      chk("midrst_write", {31'd0, avm_write}, 32'd0);
      exp_score = 0;
      for (int i = 0; i < 32; i++) init_mem[i] = mem[i];
      run_pass("after_reset", 1'b0);

      board_two_lines();
      run_pass("start_held", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
